// File: rtl/led_pwm_ctrl.sv
// Eight-channel LED PWM brightness controller with shadow registers
// that are committed to the active set only at a PWM frame boundary.
module led_pwm_ctrl #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                Mv2_CLK,
  input  logic                Mv2_RST,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  output logic                frame_tick,
  output logic [7:0]          Mv2_LED
);

  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  // Last PWM step is MAX-1 = 2^PWM_BITS - 2.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow [8];
  logic [PWM_BITS-1:0] active [8];
  logic                step;
  logic                commit;
  logic                accept;

  always_comb begin
    step     = (presc == PRESC_LAST);
    commit   = step && (pwm_cnt == CNT_LAST);
    wr_ready = !Mv2_RST && !commit;
    accept   = wr_valid && wr_ready;
  end

  always_ff @(posedge Mv2_CLK) begin
    if (Mv2_RST) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
      Mv2_LED    <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      presc <= step ? '0 : presc + 1'b1;
      if (step) begin
        pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
      end
      frame_tick <= commit;
      if (accept) begin
        shadow[wr_addr] <= wr_data;
      end
      if (commit) begin
        for (int unsigned i = 0; i < 8; i++) begin
          active[i] <= shadow[i];
        end
      end
      // Output register compares the pre-edge count/active, hence one cycle of lag.
      for (int unsigned i = 0; i < 8; i++) begin
        Mv2_LED[i] <= (pwm_cnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: frame-position reference model feeds a
// queue of per-cycle expectations; a monitor compares on the falling edge.
module tb_led_pwm_ctrl;

  localparam int P    = 2;
  localparam int MAXV = 15;
  localparam int F    = P * MAXV;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_valid, wr_ready, frame_tick;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] led;

  logic       d_rst, d_valid, d_ready, d_tick;
  logic [2:0] d_addr;
  logic [3:0] d_data;
  logic [7:0] d_led;

  led_pwm_ctrl #(.PRESCALE(P), .PWM_BITS(4)) dut (
    .Mv2_CLK(clk), .Mv2_RST(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_tick(frame_tick), .Mv2_LED(led)
  );

  led_pwm_ctrl #(.PRESCALE(1000), .PWM_BITS(4)) dut_def (
    .Mv2_CLK(clk), .Mv2_RST(d_rst), .wr_valid(d_valid), .wr_ready(d_ready),
    .wr_addr(d_addr), .wr_data(d_data), .frame_tick(d_tick), .Mv2_LED(d_led)
  );

  typedef struct {
    logic [7:0] led;
    logic       tick;
    logic       commit;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_k = 0;
  int unsigned shadow[8];
  int unsigned active[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset release fixes the frame position.
  initial forever begin
    exp_t e;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] = 0;
        active[i] = 0;
      end
      m_k      = 0;
      e.led    = 8'h00;
      e.tick   = 1'b0;
      e.commit = 1'b0;
    end else begin
      int unsigned pos, lvl;
      logic        commit_now;
      pos        = m_k % F;
      lvl        = pos / P;
      commit_now = (pos == F - 1);
      for (int i = 0; i < 8; i++) e.led[i] = (lvl < active[i]);
      if (wr_valid && !commit_now) shadow[wr_addr] = int'(wr_data);
      if (commit_now) for (int i = 0; i < 8; i++) active[i] = shadow[i];
      m_k++;
      e.tick   = commit_now;
      e.commit = ((m_k % F) == F - 1);
    end
    sb.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("led", {24'd0, led}, {24'd0, e.led});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, e.tick});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, !rst && !e.commit});
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic finish_write();
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    chk("write_accept", {31'd0, acc}, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    finish_write();
  endtask

  task automatic wait_pos(input int unsigned pos);
    int n;
    n = 0;
    while ((m_k % F) != pos && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_pos", m_k % F, pos);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic default_param_test();
    int idx, first_tick, second_tick, hi_in, hi_early, stray;
    first_tick  = -1;
    second_tick = -1;
    hi_in       = 0;
    hi_early    = 0;
    stray       = 0;
    d_rst = 1'b1;
    run(2);
    d_rst   = 1'b0;
    d_addr  = 3'd5;
    d_data  = 4'd1;
    d_valid = 1'b1;
    @(negedge clk);
    chk("def_ready", {31'd0, d_ready}, 32'd1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    idx = 1;
    while (idx <= 30001) begin
      @(negedge clk);
      if (d_tick) begin
        if (first_tick < 0) first_tick = idx;
        else if (second_tick < 0) second_tick = idx;
      end
      if (idx < 15000 && d_led[5]) hi_early++;
      if (idx >= 15000 && idx < 30000 && d_led[5]) hi_in++;
      if ((d_led & 8'hdf) != 8'h00) stray++;
      @(posedge clk);
      idx++;
    end
    #1;
    chk("def_first_tick", first_tick, 15000);
    chk("def_tick_period", second_tick - first_tick, 15000);
    chk("def_led5_high", hi_in, 1000);
    chk("def_led5_early", hi_early, 0);
    chk("def_other_leds", stray, 0);
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 3'd0;
    wr_data  = 4'd15;
    d_rst    = 1'b1;
    d_valid  = 1'b0;
    d_addr   = 3'd0;
    d_data   = 4'd0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    finish_write();
    do_write(3'd7, 4'd5);
    do_write(3'd3, 4'd8);
    do_write(3'd3, 4'd2);
    wait_pos(F - 1);
    do_write(3'd1, 4'd7);
    run(3 * F);

    for (int i = 0; i < 8; i++) do_write(3'(i), 4'd15);
    run(F);
    do_write(3'd2, 4'd1);
    wait_pos(15);
    pulse_reset();
    run(3 * F);

    repeat (150) begin
      if ($urandom_range(0, 3) == 0) run(int'($urandom_range(1, 10)));
      do_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    run(2 * F);
    wait_pos($urandom_range(1, F - 2));
    pulse_reset();
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) run(int'($urandom_range(1, 6)));
      do_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    run(3 * F);

    default_param_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
